pc_blk: RTL and testbench

- Program-counter block for the tinyarch core.
- Holds the address of the current instruction and updates it once per enabled clock.
- Next address is one of: sequential step, relative skip, conditional relative skip, or absolute jump.
- Output feeds the instruction memory address; mode and operands come from the decoder/ALU condition path.

---
 rtl/pc_blk_if.sv | 24 ++
 rtl/pc_blk.sv | 45 ++++
 tb/tb_pc_blk.sv | 119 +++++++++++
 3 files changed

// File: rtl/pc_blk_if.sv
// Decoder/ALU-to-PC bus: next-PC selection inputs and the current instruction address.
interface pc_blk_if #(
   parameter int ADDR_W  = 16,
   parameter int JADDR_W = 8
);
   logic               enable;
   logic [1:0]         jump_mode;
   logic               cond_skip_enable;
   logic [ADDR_W-1:0]  skip_amount;
   logic [JADDR_W-1:0] jump_addr;
   logic [ADDR_W-1:0]  cur_instr_addr;

   // Decoder side: drives selection and operands, reads the PC.
   modport master (
      output enable, jump_mode, cond_skip_enable, skip_amount, jump_addr,
      input  cur_instr_addr
   );

   // PC block side.
   modport slave (
      input  enable, jump_mode, cond_skip_enable, skip_amount, jump_addr,
      output cur_instr_addr
   );
endinterface

// File: rtl/pc_blk.sv
// Program counter for the tinyarch core: step, skip, conditional skip or absolute jump.
module pc_blk #(
   parameter int ADDR_W  = 16,
   parameter int JADDR_W = 8
) (
   input  logic  clk,
   input  logic  reset,
   pc_blk_if.slave bus
);
   localparam logic [1:0] MODE_STEP  = 2'd0;
   localparam logic [1:0] MODE_SKIP  = 2'd1;
   localparam logic [1:0] MODE_CSKIP = 2'd2;
   localparam logic [1:0] MODE_JUMP  = 2'd3;

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_skip;

   // Candidate addresses; sums wrap silently modulo 2^ADDR_W.
   assign pc_inc  = pc_q + ADDR_W'(1);
   assign pc_skip = pc_q + bus.skip_amount;

   // Next-PC select; holds when not enabled.
   always_comb begin
      pc_d = pc_q;
      if (bus.enable) begin
         case (bus.jump_mode)
            MODE_STEP:  pc_d = pc_inc;
            MODE_SKIP:  pc_d = pc_skip;
            MODE_CSKIP: pc_d = bus.cond_skip_enable ? pc_skip : pc_inc;
            MODE_JUMP:  pc_d = {{(ADDR_W-JADDR_W){1'b0}}, bus.jump_addr};
            default:    pc_d = pc_q;
         endcase
      end
   end

   // PC register; reset wins over enable.
   always_ff @(posedge clk) begin
      if (reset) pc_q <= '0;
      else       pc_q <= pc_d;
   end

   assign bus.cur_instr_addr = pc_q;
endmodule

// File: tb/tb_pc_blk.sv
// Directed bench for pc_blk: stimulus pushes expected PCs, a monitor pops and checks each edge.
module tb_pc_blk;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;

   logic [15:0] exp_q[$];
   string       name_q[$];

   pc_blk_if #(.ADDR_W(16), .JADDR_W(8)) bus ();

   pc_blk #(.ADDR_W(16), .JADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Apply one edge's inputs at the falling edge; expectation is the PC after the next rising edge.
   // src models an upstream value; only its low 8 bits reach jump_addr.
   task automatic step(input logic r, input logic en, input logic [1:0] m,
                       input logic c, input logic [15:0] sk, input logic [15:0] src,
                       input logic [15:0] exp_pc, input string nm);
      @(negedge clk);
      reset                = r;
      bus.enable           = en;
      bus.jump_mode        = m;
      bus.cond_skip_enable = c;
      bus.skip_amount      = sk;
      bus.jump_addr        = src[7:0];
      exp_q.push_back(exp_pc);
      name_q.push_back(nm);
   endtask

   // Monitor: one expected value per rising edge while any are queued.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            logic [15:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_chk++;
            if (bus.cur_instr_addr !== e) begin
               n_fail++;
               $display("FAIL %s: got 0x%04h expected 0x%04h", nm, bus.cur_instr_addr, e);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      bus.enable = 1'b0;
      bus.jump_mode = 2'd0;
      bus.cond_skip_enable = 1'b0;
      bus.skip_amount = '0;
      bus.jump_addr = '0;

      //   rst en  mode cond skip      src       expected
      step(1, 0, 2'd0, 0, 16'd4,    16'h00,   16'h0000, "reset0");
      step(1, 0, 2'd0, 0, 16'd4,    16'h00,   16'h0000, "reset1");
      step(0, 1, 2'd0, 0, 16'd4,    16'h00,   16'h0001, "step1");
      step(0, 1, 2'd0, 0, 16'd4,    16'h00,   16'h0002, "step2");
      step(0, 1, 2'd0, 0, 16'd4,    16'h00,   16'h0003, "step3");
      step(0, 1, 2'd1, 0, 16'd4,    16'h00,   16'h0007, "skip4");
      step(0, 1, 2'd2, 0, 16'd4,    16'h00,   16'h0008, "cskip_false");
      step(0, 1, 2'd2, 1, 16'd4,    16'h00,   16'h000C, "cskip_true");
      step(0, 1, 2'd3, 1, 16'd4,    16'hA5,   16'h00A5, "jump_a5");
      step(0, 1, 2'd3, 0, 16'd4,    16'hFF,   16'h00FF, "jump_ff");
      step(0, 0, 2'd1, 0, 16'd100,  16'h00,   16'h00FF, "hold1");
      step(0, 0, 2'd1, 0, 16'd100,  16'h00,   16'h00FF, "hold2");
      step(0, 0, 2'd1, 0, 16'd100,  16'h00,   16'h00FF, "hold3");
      step(0, 1, 2'd0, 0, 16'd0,    16'h00,   16'h0100, "reenable_step");
      // mode 0 ignores cond, skip and jump
      step(0, 1, 2'd0, 1, 16'd100,  16'hFF,   16'h0101, "step_ignores");
      // mode 1 ignores cond and jump
      step(0, 1, 2'd1, 1, 16'd2,    16'h33,   16'h0103, "skip_ignores");
      // wrap-around
      step(1, 0, 2'd0, 0, 16'd0,    16'h00,   16'h0000, "reset_wrap");
      step(0, 1, 2'd1, 0, 16'hFFFE, 16'h00,   16'hFFFE, "skip_fffe");
      step(0, 1, 2'd0, 0, 16'd0,    16'h00,   16'hFFFF, "step_ffff");
      step(0, 1, 2'd0, 0, 16'd0,    16'h00,   16'h0000, "step_wrap");
      step(0, 1, 2'd3, 0, 16'd0,    16'h10,   16'h0010, "jump_10");
      step(0, 1, 2'd1, 0, 16'hFFF5, 16'h00,   16'h0005, "skip_wrap");
      // zero skip holds
      step(0, 1, 2'd1, 0, 16'd0,    16'h00,   16'h0005, "skip_zero");
      step(0, 1, 2'd2, 1, 16'd0,    16'h00,   16'h0005, "cskip_zero");
      // upstream 512 truncates to 0x00
      step(0, 1, 2'd3, 1, 16'd7,    16'd512,  16'h0000, "jump_trunc");
      // reset mid-run beats enable
      step(0, 1, 2'd3, 0, 16'd0,    16'h40,   16'h0040, "jump_40");
      step(1, 1, 2'd1, 0, 16'd8,    16'h00,   16'h0000, "reset_mid");
      step(0, 1, 2'd0, 0, 16'd8,    16'h00,   16'h0001, "post_reset_step");

      // Drain scoreboard with a bounded wait.
      begin
         int k;
         k = 0;
         while (exp_q.size() > 0 && k < 20) begin
            @(posedge clk);
            k++;
         end
         #2;
         n_chk++;
         if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
